// File: rtl/l1cache_assoc.sv
// Private per-core L1 video cache: WAYS-way set associative, write-through with
// write-allocate to the shared L2, L2 invalidation port and whole-cache flush sweep.
module l1cache_assoc #(
  parameter int ADDR_W     = 17,
  parameter int LINE_BYTES = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic                                   w,
  input  logic [ADDR_W-1:0]                      addr,
  input  logic [7:0]                             d_in,
  output logic [7:0]                             d_out,
  output logic                                   ready,
  output logic                                   l2_en,
  output logic                                   l2_w,
  output logic [ADDR_W-$clog2(LINE_BYTES)-1:0]   l2_addr,
  output logic [8*LINE_BYTES-1:0]                l2_in,
  input  logic [8*LINE_BYTES-1:0]                l2_out,
  input  logic                                   l2_ready,
  input  logic                                   invalidate,
  input  logic [ADDR_W-$clog2(LINE_BYTES)-1:0]   inv_addr,
  output logic                                   invalidated,
  input  logic                                   flush,
  output logic                                   flush_done,
  input  logic [7:0]                             sw_in
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LA_W   = ADDR_W - OFF_W;
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int MA_W   = IDX_W + WAY_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SW     = 3'd1;
  localparam logic [2:0] ST_RD     = 3'd2;
  localparam logic [2:0] ST_WRL    = 3'd3;
  localparam logic [2:0] ST_REFILL = 3'd4;
  localparam logic [2:0] ST_FLUSH  = 3'd5;

  function automatic logic [MA_W-1:0] mem_addr(input logic [IDX_W-1:0] s,
                                               input logic [WAY_W-1:0] wy);
    return MA_W'(s) * MA_W'(WAYS) + MA_W'(wy);
  endfunction

  function automatic logic [7:0] get_byte(input logic [LINE_W-1:0] line,
                                          input logic [OFF_W-1:0]  off);
    return line[{off, 3'b000} +: 8];
  endfunction

  function automatic logic [LINE_W-1:0] set_byte(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [7:0]        b);
    logic [LINE_W-1:0] r;
    r = line;
    r[{off, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] ptr_inc(input logic [WAY_W-1:0] p);
    return (p == WAY_W'(WAYS - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [2:0]        state_r, state_nx;
  logic [IDX_W-1:0]  cnt_r, cnt_nx;
  logic              l2_en_r, l2_w_r, flush_done_r;
  logic [7:0]        d_out_r;
  logic [LINE_W-1:0] line_r;
  logic [WAY_W-1:0]  way_r;

  logic [WAYS-1:0]   valid_r [SETS];
  logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
  logic [WAY_W-1:0]  ptr_r   [SETS];
  logic [LINE_W-1:0] data_mem [SETS*WAYS];

  logic [OFF_W-1:0]  off_s;
  logic [IDX_W-1:0]  idx_s, inv_idx_s;
  logic [TAG_W-1:0]  tag_s, inv_tag_s;
  logic [LA_W-1:0]   req_line_s;
  logic              sw_addr_s, inv_req_s, hit_s, ready_s;
  logic [WAYS-1:0]   match_s, inv_match_s;
  logic [WAY_W-1:0]  hit_way_s, vic_s;
  logic [LINE_W-1:0] rd_line_s, mem_wd_s;
  logic [MA_W-1:0]   mem_wa_s;
  logic              mem_we_s;

  assign off_s      = addr[OFF_W-1:0];
  assign idx_s      = addr[OFF_W +: IDX_W];
  assign tag_s      = addr[ADDR_W-1 -: TAG_W];
  assign req_line_s = addr[ADDR_W-1:OFF_W];
  assign inv_idx_s  = inv_addr[IDX_W-1:0];
  assign inv_tag_s  = inv_addr[LA_W-1:IDX_W];
  assign sw_addr_s  = &addr;
  assign inv_req_s  = invalidate && (inv_addr == req_line_s);
  assign hit_s      = (|match_s) && !inv_req_s;
  assign vic_s      = ptr_r[idx_s];
  assign rd_line_s  = data_mem[mem_addr(idx_s, hit_way_s)];

  // Tag compare for the core request and for the invalidation port
  always_comb begin
    match_s     = '0;
    inv_match_s = '0;
    hit_way_s   = '0;
    for (int i = 0; i < WAYS; i++) begin
      match_s[i]     = valid_r[idx_s][i] && (tag_r[idx_s][i] == tag_s);
      inv_match_s[i] = valid_r[inv_idx_s][i] && (tag_r[inv_idx_s][i] == inv_tag_s);
      hit_way_s      = hit_way_s | (match_s[i] ? WAY_W'(i) : '0);
    end
  end

  // Next-state and flush counter
  always_comb begin
    state_nx = ST_IDLE;
    cnt_nx   = (state_r == ST_FLUSH) ? cnt_r + 1'b1 : '0;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_nx = ST_FLUSH;
        end else if (en && sw_addr_s) begin
          state_nx = ST_SW;
        end else if (en && hit_s) begin
          state_nx = w ? ST_WRL : ST_RD;
        end else if (en) begin
          state_nx = ST_REFILL;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SW:     state_nx = ST_IDLE;
      ST_RD:     state_nx = ST_IDLE;
      ST_WRL:    state_nx = l2_ready ? ST_IDLE : ST_WRL;
      ST_REFILL: state_nx = l2_ready ? ST_IDLE : ST_REFILL;
      ST_FLUSH:  state_nx = (cnt_r == IDX_W'(SETS - 1)) ? ST_IDLE : ST_FLUSH;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // ready must be withdrawn in the same cycle an invalidation hits the line being read
  always_comb begin
    ready_s = 1'b0;
    if (!rst_n) begin
      ready_s = 1'b0;
    end else begin
      ready_s = (state_r == ST_SW) ||
                ((state_r == ST_RD) && !inv_req_s) ||
                ((state_r == ST_WRL) && l2_ready);
    end
  end

  // Data-array write port: refill into the victim way, or write-through merge into the hit way
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = mem_addr(idx_s, vic_s);
    mem_wd_s = l2_out;
    if (rst_n && l2_ready && (state_r == ST_REFILL)) begin
      mem_we_s = 1'b1;
    end else if (rst_n && l2_ready && (state_r == ST_WRL)) begin
      mem_we_s = 1'b1;
      mem_wa_s = mem_addr(idx_s, way_r);
      mem_wd_s = line_r;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Data array storage
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      data_mem[mem_wa_s] <= mem_wd_s;
    end
  end

  // Control state, registered outputs and the registered data-array read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      l2_en_r      <= 1'b0;
      l2_w_r       <= 1'b0;
      flush_done_r <= 1'b0;
      d_out_r      <= 8'h00;
      line_r       <= '0;
      way_r        <= '0;
    end else begin
      state_r      <= state_nx;
      cnt_r        <= cnt_nx;
      l2_en_r      <= (state_nx == ST_REFILL) || (state_nx == ST_WRL);
      l2_w_r       <= (state_nx == ST_WRL);
      flush_done_r <= (state_nx == ST_FLUSH) && (cnt_nx == IDX_W'(SETS - 1));
      if (state_nx == ST_SW) begin
        d_out_r <= sw_in;
      end else if (state_nx == ST_RD) begin
        d_out_r <= get_byte(rd_line_s, off_s);
      end
      if ((state_r == ST_IDLE) && (state_nx == ST_WRL)) begin
        line_r <= set_byte(rd_line_s, off_s, d_in);
        way_r  <= hit_way_s;
      end
    end
  end

  // Valid/tag/victim-pointer arrays; the invalidation clear is last so it overrides
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        ptr_r[s]   <= '0;
      end
    end else begin
      if ((state_r == ST_REFILL) && l2_ready) begin
        valid_r[idx_s][vic_s] <= !inv_req_s;
        tag_r[idx_s][vic_s]   <= tag_s;
        ptr_r[idx_s]          <= ptr_inc(vic_s);
      end else if (state_r == ST_FLUSH) begin
        valid_r[cnt_r] <= '0;
      end
      if (invalidate) begin
        for (int i = 0; i < WAYS; i++) begin
          if (inv_match_s[i]) begin
            valid_r[inv_idx_s][i] <= 1'b0;
          end
        end
      end
    end
  end

  assign d_out       = d_out_r;
  assign ready       = ready_s;
  assign l2_en       = l2_en_r;
  assign l2_w        = l2_w_r;
  assign l2_addr     = req_line_s;
  assign l2_in       = line_r;
  assign invalidated = invalidate;
  assign flush_done  = flush_done_r;

endmodule
